pipe_ctrl: RTL and testbench

//  Central pipeline sequencer. Drives stall[5:0] into pc_reg/if_id/id_ex/ex_mem/mem_wb and raises flush.

---
 rtl/pipe_ctrl_if.sv | 34 +++
 rtl/pipe_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline sequencer request/control bundle
interface pipe_ctrl_if #(
   parameter int EX_CNT_W = 6,
   parameter int DATA_W   = 32
);
   // Requests from the pipeline stages
   logic                stallreq_id;
   logic                ex_start;
   logic [EX_CNT_W-1:0] ex_cycles;
   logic                mem_req;
   logic                mem_ack;
   logic                flush_req;
   logic [DATA_W-1:0]   flush_pc;

   // Control returned to the pipeline
   logic [5:0]          stall;
   logic                flush;
   logic [DATA_W-1:0]   new_pc;
   logic                ex_done;
   logic                mem_err;
   logic                busy;

   // Pipeline side: raises requests, consumes stall/flush
   modport master (
      output stallreq_id, ex_start, ex_cycles, mem_req, mem_ack, flush_req, flush_pc,
      input  stall, flush, new_pc, ex_done, mem_err, busy
   );

   // Sequencer side
   modport slave (
      input  stallreq_id, ex_start, ex_cycles, mem_req, mem_ack, flush_req, flush_pc,
      output stall, flush, new_pc, ex_done, mem_err, busy
   );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - central pipeline stall/flush sequencer
module pipe_ctrl #(
   parameter int EX_CNT_W    = 6,
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 5,
   parameter int DATA_W      = 32
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave io_pipe
);

   // Stall vector bit map: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] wb
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
   localparam logic [TMO_W-1:0]    TMO_MAX  = {TMO_W{1'b1}};
   localparam logic [EX_CNT_W-1:0] CNT_ONE  = EX_CNT_W'(1);
   localparam logic [EX_CNT_W-1:0] CNT_TWO  = EX_CNT_W'(2);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EX_BUSY  = 2'd1,
      MEM_WAIT = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   state_t              r_state;
   logic [EX_CNT_W-1:0] r_cnt;
   logic [TMO_W-1:0]    r_tmo;
   logic                r_flush;
   logic [DATA_W-1:0]   r_new_pc;
   logic                r_ex_done;
   logic                r_mem_err;

   logic [5:0]          w_stall;
   logic                w_ex_long;
   logic                w_ex_more;
   logic                w_tmo_last;

   // N of 0 or 1 finishes without stalling, so only N>=2 needs the EX_BUSY state
   assign w_ex_long  = (io_pipe.ex_cycles >= CNT_TWO);
   // Counter above 1 means at least one more stalled cycle remains
   assign w_ex_more  = (r_cnt > CNT_ONE);
   assign w_tmo_last = (r_tmo == TMO_LAST);

   // Combinational stall decode; priority flush > MEM > EX > ID, zero while in reset
   always_comb begin
      w_stall = STALL_NONE;
      if (rst) begin
         case (r_state)
            IDLE: begin
               if (io_pipe.flush_req) begin
                  w_stall = STALL_NONE;
               end else if (io_pipe.mem_req) begin
                  // Ack arriving together with the request costs no stall
                  if (!io_pipe.mem_ack) w_stall = STALL_MEM;
               end else if (io_pipe.ex_start) begin
                  if (w_ex_long) w_stall = STALL_EX;
               end else if (io_pipe.stallreq_id) begin
                  w_stall = STALL_ID;
               end
            end
            EX_BUSY: begin
               if (!io_pipe.flush_req && w_ex_more) w_stall = STALL_EX;
            end
            MEM_WAIT: begin
               // Timeout cycle still stalls; the flush follows on the next cycle
               if (!io_pipe.flush_req && io_pipe.mem_req && !io_pipe.mem_ack)
                  w_stall = STALL_MEM;
            end
            default: w_stall = STALL_NONE;
         endcase
      end
   end

   // Sequencer FSM with registered flush/new_pc/ex_done/mem_err
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_tmo     <= '0;
         r_flush   <= 1'b0;
         r_new_pc  <= '0;
         r_ex_done <= 1'b0;
         r_mem_err <= 1'b0;
      end else begin
         r_ex_done <= 1'b0;
         r_mem_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (io_pipe.flush_req) begin
                  r_state  <= FLUSH;
                  r_flush  <= 1'b1;
                  r_new_pc <= io_pipe.flush_pc;
               end else if (io_pipe.mem_req) begin
                  if (!io_pipe.mem_ack) begin
                     r_state <= MEM_WAIT;
                     r_tmo   <= '0;
                  end
               end else if (io_pipe.ex_start) begin
                  if (w_ex_long) begin
                     r_state <= EX_BUSY;
                     r_cnt   <= io_pipe.ex_cycles - CNT_ONE;
                  end else begin
                     r_ex_done <= 1'b1;
                  end
               end
            end
            EX_BUSY: begin
               if (io_pipe.flush_req) begin
                  // Aborted op: no ex_done will be reported
                  r_state  <= FLUSH;
                  r_flush  <= 1'b1;
                  r_new_pc <= io_pipe.flush_pc;
                  r_cnt    <= '0;
               end else if (w_ex_more) begin
                  r_cnt <= r_cnt - CNT_ONE;
               end else begin
                  r_state   <= IDLE;
                  r_cnt     <= '0;
                  r_ex_done <= 1'b1;
               end
            end
            MEM_WAIT: begin
               if (io_pipe.flush_req) begin
                  r_state  <= FLUSH;
                  r_flush  <= 1'b1;
                  r_new_pc <= io_pipe.flush_pc;
                  r_tmo    <= '0;
               end else if (io_pipe.mem_ack || !io_pipe.mem_req) begin
                  r_state <= IDLE;
                  r_tmo   <= '0;
               end else if (w_tmo_last) begin
                  // Bus timeout redirects to address zero
                  r_state   <= FLUSH;
                  r_flush   <= 1'b1;
                  r_new_pc  <= '0;
                  r_mem_err <= 1'b1;
                  r_tmo     <= '0;
               end else if (r_tmo != TMO_MAX) begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            FLUSH: begin
               if (io_pipe.flush_req) begin
                  // Back-to-back redirect extends the flush by one cycle
                  r_new_pc <= io_pipe.flush_pc;
               end else begin
                  r_state <= IDLE;
                  r_flush <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_flush <= 1'b0;
            end
         endcase
      end
   end

   assign io_pipe.stall   = w_stall;
   assign io_pipe.flush   = r_flush;
   assign io_pipe.new_pc  = r_new_pc;
   assign io_pipe.ex_done = r_ex_done;
   assign io_pipe.mem_err = r_mem_err;
   assign io_pipe.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

   logic clk;
   logic rst;

   pipe_ctrl_if #(.EX_CNT_W(6), .DATA_W(32)) bus ();

   pipe_ctrl #(
      .EX_CNT_W(6),
      .MEM_TIMEOUT(16),
      .TMO_W(5),
      .DATA_W(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io_pipe(bus.slave)
   );

   typedef struct {
      string       nm;
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        chk_pc;
      logic        done;
      logic        err;
      logic        busy;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the outputs expected during that cycle
   task automatic step(input string nm, input logic r, input logic id, input logic exs,
                       input logic [5:0] n, input logic mreq, input logic mack,
                       input logic freq, input logic [31:0] fpc,
                       input logic [5:0] es, input logic ef, input logic [31:0] epc,
                       input logic ed, input logic ee, input logic eb);
      exp_t e;
      @(posedge clk);
      #1;
      rst              = r;
      bus.stallreq_id  = id;
      bus.ex_start     = exs;
      bus.ex_cycles    = n;
      bus.mem_req      = mreq;
      bus.mem_ack      = mack;
      bus.flush_req    = freq;
      bus.flush_pc     = fpc;
      e.nm     = nm;
      e.stall  = es;
      e.flush  = ef;
      e.pc     = epc;
      e.chk_pc = ef | ~r;
      e.done   = ed;
      e.err    = ee;
      e.busy   = eb;
      q.push_back(e);
   endtask

   // Monitor: compare on the falling edge, away from the active edge
   always @(negedge clk) begin : monitor
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (bus.stall !== e.stall || bus.flush !== e.flush || bus.ex_done !== e.done ||
             bus.mem_err !== e.err || bus.busy !== e.busy ||
             (e.chk_pc && bus.new_pc !== e.pc)) begin
            errors++;
            $display("FAIL %s: got stall=%b flush=%b new_pc=%h ex_done=%b mem_err=%b busy=%b, want stall=%b flush=%b new_pc=%h(chk=%b) ex_done=%b mem_err=%b busy=%b",
                     e.nm, bus.stall, bus.flush, bus.new_pc, bus.ex_done, bus.mem_err, bus.busy,
                     e.stall, e.flush, e.pc, e.chk_pc, e.done, e.err, e.busy);
         end
      end
   end

   initial begin
      rst             = 1'b0;
      bus.stallreq_id = 1'b0;
      bus.ex_start    = 1'b0;
      bus.ex_cycles   = 6'd0;
      bus.mem_req     = 1'b0;
      bus.mem_ack     = 1'b0;
      bus.flush_req   = 1'b0;
      bus.flush_pc    = 32'h0;

      //    name        rst id exs n  mreq mack freq fpc            stall  flush pc            done err busy
      // T1 reset with active requests
      step("rst_a",     0, 0, 1, 5, 1, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      step("rst_b",     0, 0, 1, 5, 1, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      step("rst_rel",   1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // T2 load-use
      step("id_stall",  1, 1, 0, 0, 0, 0, 0, 32'h0,          6'h07, 0, 32'h0,          0, 0, 0);
      step("id_clear",  1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // T3 EX N=5, with ID and ex_start ignored while busy
      step("ex5_start", 1, 0, 1, 5, 0, 0, 0, 32'h0,          6'h0F, 0, 32'h0,          0, 0, 0);
      step("ex5_c4",    1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h0F, 0, 32'h0,          0, 0, 1);
      step("ex5_c3_id", 1, 1, 0, 0, 0, 0, 0, 32'h0,          6'h0F, 0, 32'h0,          0, 0, 1);
      step("ex5_c2_ex", 1, 0, 1, 3, 0, 0, 0, 32'h0,          6'h0F, 0, 32'h0,          0, 0, 1);
      step("ex5_c1",    1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 1);
      step("ex5_done",  1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          1, 0, 0);
      step("ex5_after", 1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // N=1 and N=0: no stall, ex_done next cycle
      step("ex1_start", 1, 0, 1, 1, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      step("ex1_done",  1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          1, 0, 0);
      step("ex1_after", 1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      step("ex0_start", 1, 0, 1, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      step("ex0_done",  1, 1, 0, 0, 0, 0, 0, 32'h0,          6'h07, 0, 32'h0,          1, 0, 0);
      step("ex0_after", 1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // T4 MEM ack after 3 stalled cycles
      step("mem_req",   1, 0, 0, 0, 1, 0, 0, 32'h0,          6'h1F, 0, 32'h0,          0, 0, 0);
      step("mem_w1",    1, 0, 0, 0, 1, 0, 0, 32'h0,          6'h1F, 0, 32'h0,          0, 0, 1);
      step("mem_w2",    1, 0, 0, 0, 1, 0, 0, 32'h0,          6'h1F, 0, 32'h0,          0, 0, 1);
      step("mem_ack",   1, 0, 0, 0, 1, 1, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 1);
      step("mem_idle",  1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // mem_req drops while waiting: back to IDLE, no error
      step("mdrop_req", 1, 0, 0, 0, 1, 0, 0, 32'h0,          6'h1F, 0, 32'h0,          0, 0, 0);
      step("mdrop_low", 1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 1);
      step("mdrop_idl", 1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // T5 priority: everything at once in IDLE
      step("prio_req",  1, 1, 1, 4, 1, 0, 1, 32'h12345678,   6'h00, 0, 32'h0,          0, 0, 0);
      step("prio_fl",   1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 1, 32'h12345678,   0, 0, 1);
      step("prio_idl",  1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      step("prio_nodn", 1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // flush_req while in FLUSH re-latches and extends
      step("refl_req",  1, 0, 0, 0, 0, 0, 1, 32'hAAAA0000,   6'h00, 0, 32'h0,          0, 0, 0);
      step("refl_req2", 1, 0, 0, 0, 0, 0, 1, 32'hBBBB0004,   6'h00, 1, 32'hAAAA0000,   0, 0, 1);
      step("refl_fl2",  1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 1, 32'hBBBB0004,   0, 0, 1);
      step("refl_idl",  1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // T4 timeout: 1 IDLE cycle then 16 MEM_WAIT cycles without ack
      step("tmo_req",   1, 0, 0, 0, 1, 0, 0, 32'h0,          6'h1F, 0, 32'h0,          0, 0, 0);
      for (int i = 0; i < 16; i++)
         step("tmo_wait", 1, 0, 0, 0, 1, 0, 0, 32'h0,        6'h1F, 0, 32'h0,          0, 0, 1);
      step("tmo_err",   1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 1, 32'h0,          0, 1, 1);
      step("tmo_idl",   1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // T6 abort N=6 at cnt=2
      step("abt_start", 1, 0, 1, 6, 0, 0, 0, 32'h0,          6'h0F, 0, 32'h0,          0, 0, 0);
      step("abt_c5",    1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h0F, 0, 32'h0,          0, 0, 1);
      step("abt_c4",    1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h0F, 0, 32'h0,          0, 0, 1);
      step("abt_c3",    1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h0F, 0, 32'h0,          0, 0, 1);
      step("abt_c2_fl", 1, 0, 0, 0, 0, 0, 1, 32'hC0DE0010,   6'h00, 0, 32'h0,          0, 0, 1);
      step("abt_flush", 1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 1, 32'hC0DE0010,   0, 0, 1);
      step("abt_idl",   1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      step("abt_nodn",  1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // flush during MEM_WAIT aborts without mem_err
      step("mfl_req",   1, 0, 0, 0, 1, 0, 0, 32'h0,          6'h1F, 0, 32'h0,          0, 0, 0);
      step("mfl_fl",    1, 0, 0, 0, 1, 0, 1, 32'hD00D0020,   6'h00, 0, 32'h0,          0, 0, 1);
      step("mfl_flush", 1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 1, 32'hD00D0020,   0, 0, 1);
      step("mfl_idl",   1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      // async reset in the middle of MEM_WAIT
      step("ars_req",   1, 0, 0, 0, 1, 0, 0, 32'h0,          6'h1F, 0, 32'h0,          0, 0, 0);
      step("ars_rst",   0, 0, 0, 0, 1, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);
      step("ars_rel",   1, 0, 0, 0, 0, 0, 0, 32'h0,          6'h00, 0, 32'h0,          0, 0, 0);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d want 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
